// File: rtl/input_buffer_pingpong.sv
// Double-buffered multi-channel input activation buffer: producer fills one bank while the PE array reads the other.
// Latency: write lands on the accepting edge; read data and rd_valid appear one cycle after rd_en.
// Backpressure: wr_ready drops while both banks hold unreleased data; rd_en/rd_release are ignored while no bank is full.
module input_buffer_pingpong #(
    parameter int NUM_CH     = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 14,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    input  logic                         wr_last,
    output logic                         rd_avail,
    output logic [LEN_WIDTH-1:0]         rd_len,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_valid,
    input  logic                         rd_release
);

    logic                  wr_sel;
    logic                  rd_sel;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [1:0]            full_cnt;
    logic [LEN_WIDTH-1:0]  len [2];

    // Request-cycle copies that steer the registered RAM outputs onto rd_data.
    logic                  sel_q;
    logic                  pad_q;

    logic                  wr_acc;
    logic                  wr_close;
    logic                  rel;
    logic                  rd_acc;
    logic                  rd_pad;

    assign wr_ready = (full_cnt != 2'd2);
    assign rd_avail = (full_cnt != 2'd0);
    assign rd_len   = rd_avail ? len[rd_sel] : '0;

    assign wr_acc   = wr_valid & wr_ready;
    assign wr_close = wr_acc & (wr_last | (wr_ptr == ADDR_WIDTH'(DEPTH - 1)));
    assign rel      = rd_release & rd_avail;
    assign rd_acc   = rd_en & rd_avail;
    // Addresses past the fill length read back as zero padding.
    assign rd_pad   = (LEN_WIDTH'(rd_addr) >= len[rd_sel]);

    // Bank bookkeeping: write pointer, bank selects, full count and per-bank fill length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            wr_ptr   <= '0;
            full_cnt <= 2'd0;
            len[0]   <= '0;
            len[1]   <= '0;
        end else begin
            if (wr_close) begin
                wr_ptr <= '0;
                wr_sel <= ~wr_sel;
            end else if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            // A release and a close never address the same bank on one edge:
            // release needs a full bank, close needs a free one, so selects differ.
            if (rel) begin
                rd_sel      <= ~rd_sel;
                len[rd_sel] <= '0;
            end
            if (wr_close) begin
                len[wr_sel] <= LEN_WIDTH'(wr_ptr) + LEN_WIDTH'(1);
            end
            case ({wr_close, rel})
                2'b10:   full_cnt <= full_cnt + 2'd1;
                2'b01:   full_cnt <= full_cnt - 2'd1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    // Read handshake: rd_valid pulses per accepted read; steering state holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            sel_q    <= 1'b0;
            pad_q    <= 1'b1;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                sel_q <= rd_sel;
                pad_q <= rd_pad;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] ram0 [DEPTH];
        logic [DATA_WIDTH-1:0] ram1 [DEPTH];
        logic [DATA_WIDTH-1:0] q0;
        logic [DATA_WIDTH-1:0] q1;

        // Storage write for this channel; contents survive reset.
        always_ff @(posedge clk) begin
            if (rst_n && wr_acc) begin
                if (wr_sel) begin
                    ram1[wr_ptr] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    ram0[wr_ptr] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        // Registered RAM read ports; padded addresses skip the array access.
        always_ff @(posedge clk) begin
            if (rst_n && rd_acc && !rd_pad) begin
                q0 <= ram0[rd_addr];
                q1 <= ram1[rd_addr];
            end
        end

        assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = pad_q ? '0 : (sel_q ? q1 : q0);
    end

endmodule

// File: doc/input_buffer_pingpong.md
Name: input_buffer_pingpong

Overview:
- Parametrised double-buffered (ping-pong) multi-channel input activation buffer for the ECG accelerator.
- Replaces the fixed 16-channel x 32-bit x 14-deep single-port RAM bank.
- A streaming producer fills one bank while the PE array reads the other bank by address. Banks swap under internal fill and release handshakes.
- Supports early bank closure for short segments, and reports the fill length per bank.

Parameters:
- NUM_CH, 16, number of parallel channels (one RAM column per channel)
- DATA_WIDTH, 32, word width per channel
- DEPTH, 14, words per channel per bank (2 <= DEPTH <= 2**ADDR_WIDTH)
- ADDR_WIDTH, 4, read address width
- LEN_WIDTH, ADDR_WIDTH+1, fill-length field width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- wr_valid  in  1  producer beat valid
- wr_ready  out  1  write bank can accept a beat
- wr_data  in  NUM_CH*DATA_WIDTH  one word per channel; channel c = bits [c*DATA_WIDTH +: DATA_WIDTH]
- wr_last  in  1  close the current write bank after this beat
- rd_avail  out  1  a full bank is available for reading
- rd_len  out  LEN_WIDTH  number of valid words in the read bank (1..DEPTH); 0 when rd_avail=0
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  word address within the read bank, shared across channels
- rd_data  out  NUM_CH*DATA_WIDTH  read words, same packing as wr_data
- rd_valid  out  1  rd_data valid
- rd_release  in  1  consumer finished with the read bank

Behaviour:
- Storage: 2 banks x NUM_CH x DEPTH words. Contents are not cleared by reset.
- State registers:
  - wr_sel: bank being filled.
  - rd_sel: bank being read.
  - wr_ptr: next write address, 0..DEPTH-1.
  - full_cnt: number of full banks, 0..2.
  - len[0:1]: fill length per bank, LEN_WIDTH bits.
- Reset (rst_n=0 at a clk edge) sets:
  - wr_sel=0, rd_sel=0, wr_ptr=0, full_cnt=0, len[0]=len[1]=0.
  - Outputs: wr_ready=1, rd_avail=0, rd_len=0, rd_valid=0, rd_data=0.
- Reset mid-fill or mid-read discards all bank state; it takes effect on the very edge where rst_n is sampled low.
- Combinational outputs:
  - wr_ready = (full_cnt != 2).
  - rd_avail = (full_cnt != 0).
  - rd_len = len[rd_sel] when rd_avail, else 0.
- Write beat is accepted when wr_valid & wr_ready. On an accepted beat:
  - All NUM_CH words are written to bank wr_sel at address wr_ptr.
  - If wr_last=1 or wr_ptr==DEPTH-1, the bank closes: len[wr_sel]=wr_ptr+1, wr_ptr=0, wr_sel toggles, full_cnt increments.
  - Otherwise wr_ptr increments.
- wr_valid while wr_ready=0: no write and no pointer change. The producer holds its data.
- Read: 1-cycle latency.
  - If rd_en & rd_avail at edge N, then at edge N+1: rd_valid=1 and rd_data = bank rd_sel at rd_addr.
  - If rd_addr >= len[rd_sel], rd_data is all zeros (zero padding for convolution edges), with rd_valid=1.
  - If rd_en while rd_avail=0: ignored; rd_valid=0 next cycle.
  - rd_data holds its last value when rd_valid=0.
- Release:
  - rd_release & rd_avail: rd_sel toggles, full_cnt decrements, len[old rd_sel] cleared to 0.
  - rd_release while rd_avail=0: ignored.
- Simultaneous events:
  - Bank close and release on the same edge: full_cnt unchanged, wr_sel and rd_sel both toggle.
  - rd_en and rd_release on the same edge: the read uses the pre-release rd_sel.
- Write/read conflict on one bank is impossible by construction: wr_sel==rd_sel only when full_cnt is 0 or 2, and writes are blocked at 2.
- Implementation: per-channel, per-bank registered-output RAM. The read-port mux selects by rd_sel registered on the request cycle.

Test Plan:
- Reset, then 14 beats with channel c = {16'(bank), 8'(c), 8'(addr)}, wr_last=0 → after the 14th beat: rd_avail=1, rd_len=14, wr_ready=1. Read addr 5 → next cycle rd_valid=1 and ch3 word = 0x0000_0305.
- Fill bank0 and bank1 (28 beats), no release → wr_ready=0. Further wr_valid beats do not change wr_ptr. Then rd_release → wr_ready=1 in the same cycle, rd_len=14 for bank1, and reads return bank1 data.
- 6 beats with wr_last on beat 6 → rd_len=6. Read addr 5 returns data; addr 6 and addr 13 return 0 with rd_valid=1.
- Same-edge bank close and rd_release with full_cnt=1 → full_cnt stays 1, both selects toggle, no data corruption on a subsequent 14-word readback.
- rd_en and rd_release with rd_avail=0 → rd_valid=0, rd_sel unchanged. Reset asserted mid-fill at wr_ptr=7 → wr_ptr=0, rd_avail=0, rd_valid=0 on the next cycle.
- Non-default build NUM_CH=4, DATA_WIDTH=8, DEPTH=16, ADDR_WIDTH=4 → 16-beat fill closes the bank, rd_len=16 (needs all 5 bits), and readback matches.
